// File: rtl/johnson_decoder_pkg.sv
// ----------------------------------------------------------------------------
// johnson_pkg
//   Definitions shared by the Johnson counter and the Johnson decoder, so both
//   ends agree on the code sequence (MSB-first fill).
//
//   JC_WIDTH    default Johnson code width
//   JC_MAX_W    widest code the helper functions accept
//   jc_state_t  decoder tracking state {HUNT, LOCK}
//   jc_legal    1 when a code is one of the 2*width legal Johnson codes
//   jc_to_idx   phase index 0..2*width-1 of a legal code
// ----------------------------------------------------------------------------
package johnson_pkg;

    localparam int JC_WIDTH = 4;
    localparam int JC_MAX_W = 32;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        LOCK = 1'b1
    } jc_state_t;

    // A legal Johnson code has at most one 0/1 boundary between adjacent
    // bits: all zeros, all ones, ones packed from the MSB or ones packed from
    // the LSB. Bits above 'width' must be zero.
    function automatic logic jc_legal(input logic [JC_MAX_W-1:0] code,
                                      input int width);
        int edges;
        logic above;
        edges = 0;
        above = 1'b0;
        for (int i = 0; i < JC_MAX_W; i++) begin
            if (i >= width) begin
                above = above | code[i];
            end else if (i > 0) begin
                if (code[i] != code[i-1]) begin
                    edges = edges + 1;
                end
            end
        end
        return (edges <= 1) && !above;
    endfunction

    // MSB-packed ones (or all zeros): index = number of ones.
    // LSB-packed ones with MSB clear: index = 2*width - number of ones.
    function automatic int jc_to_idx(input logic [JC_MAX_W-1:0] code,
                                     input int width);
        int ones;
        logic msb;
        ones = 0;
        msb  = 1'b0;
        for (int i = 0; i < JC_MAX_W; i++) begin
            if (i < width) begin
                if (code[i]) begin
                    ones = ones + 1;
                end
                if (i == width - 1) begin
                    msb = code[i];
                end
            end
        end
        if (msb || (ones == 0)) begin
            return ones;
        end
        return 2 * width - ones;
    endfunction

endpackage

// File: rtl/johnson_decoder_if.sv
// ----------------------------------------------------------------------------
// johnson_decoder_if
//   Bundles the sample-side inputs and the decoded outputs of the Johnson
//   decoder.
//
//   master : drives en, jc_in, clr_err; observes all results
//   slave  : the decoder
//
//   en         sample enable
//   jc_in      Johnson code to decode
//   clr_err    synchronous clear of err_count
//   idx        phase index of the last legal sample
//   idx_valid  idx holds a decoded sample
//   dir_up     1 = last nonzero accepted step was +1
//   locked     tracker is in LOCK
//   illegal    one-cycle pulse, last sample was not a Johnson code
//   seq_err    one-cycle pulse, disallowed jump while locked
//   err_count  saturating count of illegal + seq_err events
//   dbg_state  tracker FSM state
// ----------------------------------------------------------------------------
interface johnson_decoder_if #(
    parameter int WIDTH = johnson_pkg::JC_WIDTH,
    parameter int ERR_W = 8
);
    import johnson_pkg::*;

    localparam int IW = $clog2(2 * WIDTH);

    logic             en;
    logic [WIDTH-1:0] jc_in;
    logic             clr_err;
    logic [IW-1:0]    idx;
    logic             idx_valid;
    logic             dir_up;
    logic             locked;
    logic             illegal;
    logic             seq_err;
    logic [ERR_W-1:0] err_count;
    jc_state_t        dbg_state;

    modport master (
        output en, jc_in, clr_err,
        input  idx, idx_valid, dir_up, locked, illegal, seq_err, err_count,
               dbg_state
    );

    modport slave (
        input  en, jc_in, clr_err,
        output idx, idx_valid, dir_up, locked, illegal, seq_err, err_count,
               dbg_state
    );

endinterface

// File: rtl/johnson_decoder_code_map.sv
// ----------------------------------------------------------------------------
// johnson_code_map
//   Combinational Johnson code classifier.
//
//   code   in   WIDTH  Johnson code
//   legal  out  1      code is one of the 2*WIDTH legal codes
//   idx    out  IW     phase index of the code (meaningful when legal)
// ----------------------------------------------------------------------------
module johnson_code_map
    import johnson_pkg::*;
#(
    parameter  int WIDTH = JC_WIDTH,
    localparam int IW    = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] code,
    output logic             legal,
    output logic [IW-1:0]    idx
);

    logic [JC_MAX_W-1:0] code_ext;

    always_comb begin
        code_ext = JC_MAX_W'(code);
        legal    = jc_legal(code_ext, WIDTH);
        idx      = IW'(jc_to_idx(code_ext, WIDTH));
    end

endmodule

// File: rtl/johnson_decoder.sv
// ----------------------------------------------------------------------------
// johnson_decoder
//   Samples a WIDTH-bit Johnson code, checks legality, decodes it to a phase
//   index 0..2*WIDTH-1, tracks stepping direction, locks after LOCK_CNT
//   consecutive legal steps and counts illegal codes / illegal jumps.
//
//   Optional feature macro: JDEC_BIDIR_EN
//     defined     : a -1 step is allowed in both states, dir_up follows the
//                   last accepted nonzero step
//     not defined : only +1 is allowed, -1 is a disallowed jump, dir_up = 1
//
//   Parameters: WIDTH (code width, >= 2), LOCK_CNT (>= 1), ERR_W
//
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset
//     bus    slave modport of johnson_decoder_if (en, jc_in, clr_err in;
//            idx, idx_valid, dir_up, locked, illegal, seq_err, err_count,
//            dbg_state out)
//
//   Handshake: there is no back-pressure. Each rising edge with en=1
//   consumes jc_in; results appear on the outputs after that same edge.
//   illegal/seq_err are high for exactly one cycle after the sampling edge.
// ----------------------------------------------------------------------------
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int WIDTH    = JC_WIDTH,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input logic           clk,
    input logic           rst_n,
    johnson_decoder_if.slave bus
);

    localparam int IW     = $clog2(2 * WIDTH);
    localparam int NCODES = 2 * WIDTH;
    localparam int RW     = $clog2(LOCK_CNT + 1);

    localparam logic [IW:0]      NC_EXT   = (IW + 1)'(NCODES);
    localparam logic [IW-1:0]    D_ONE    = IW'(1);
    localparam logic [RW-1:0]    RUN_LOCK = RW'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    // ------------------------------------------------------------------
    // Decode of the incoming sample
    // ------------------------------------------------------------------
    logic          code_legal;
    logic [IW-1:0] code_idx;

    johnson_code_map #(
        .WIDTH (WIDTH)
    ) u_code_map (
        .code  (bus.jc_in),
        .legal (code_legal),
        .idx   (code_idx)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    jc_state_t        state_q,   state_d;
    logic [IW-1:0]    idx_q,     idx_d;
    logic             valid_q,   valid_d;
    logic [RW-1:0]    run_q,     run_d;
    logic             illegal_q, illegal_d;
    logic             seq_err_q, seq_err_d;
    logic [ERR_W-1:0] err_q,     err_d;
    logic             err_inc;

    // ------------------------------------------------------------------
    // Step size d = (new - old) mod 2*WIDTH. The sum new + 2*WIDTH - old
    // is always positive and below 4*WIDTH, so one conditional subtract
    // brings it into range for any WIDTH, power of two or not.
    // ------------------------------------------------------------------
    logic [IW:0]   diff_ext;
    logic [IW-1:0] delta;
    logic          step_up;
    logic          allowed;
    logic [RW-1:0] run_inc;

    always_comb begin
        diff_ext = {1'b0, code_idx} + NC_EXT - {1'b0, idx_q};
        if (diff_ext >= NC_EXT) begin
            diff_ext = diff_ext - NC_EXT;
        end
        delta = diff_ext[IW-1:0];
    end

    assign step_up = (delta == D_ONE);
    assign run_inc = run_q + RW'(1);

`ifdef JDEC_BIDIR_EN
    localparam logic [IW-1:0] D_MINUS = IW'(NCODES - 1);

    logic step_dn;
    logic dir_q;
    logic dir_take;

    assign step_dn = (delta == D_MINUS);
    assign allowed = step_up | step_dn;

    // Any accepted nonzero step, in either state, sets the direction.
    assign dir_take = bus.en & code_legal & valid_q & allowed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= 1'b1;
        end else if (dir_take) begin
            dir_q <= step_up;
        end
    end

    assign bus.dir_up = dir_q;
`else
    assign allowed    = step_up;
    assign bus.dir_up = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Tracker FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        run_d     = run_q;
        illegal_d = 1'b0;
        seq_err_d = 1'b0;
        err_inc   = 1'b0;

        if (bus.en) begin
            if (!code_legal) begin
                // Not a Johnson code: keep the last good index, restart hunt.
                illegal_d = 1'b1;
                run_d     = '0;
                state_d   = HUNT;
                err_inc   = 1'b1;
            end else if (!valid_q) begin
                // First legal sample after reset: nothing to compare against.
                idx_d   = code_idx;
                valid_d = 1'b1;
                run_d   = '0;
            end else if (delta != '0) begin
                unique case (state_q)
                    HUNT: begin
                        idx_d = code_idx;
                        if (allowed) begin
                            run_d = run_inc;
                            if (run_inc == RUN_LOCK) begin
                                state_d = LOCK;
                            end
                        end else begin
                            // Jumps while hunting just re-seed the run.
                            run_d = '0;
                        end
                    end
                    LOCK: begin
                        idx_d = code_idx;
                        if (!allowed) begin
                            seq_err_d = 1'b1;
                            err_inc   = 1'b1;
                            run_d     = '0;
                            state_d   = HUNT;
                        end
                    end
                    default: begin
                        state_d = HUNT;
                    end
                endcase
            end
        end

        // Clear has priority over a same-edge increment.
        if (bus.clr_err) begin
            err_d = '0;
        end else if (err_inc && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_W'(1);
        end else begin
            err_d = err_q;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            run_q     <= '0;
            illegal_q <= 1'b0;
            seq_err_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            run_q     <= run_d;
            illegal_q <= illegal_d;
            seq_err_q <= seq_err_d;
            err_q     <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.idx       = idx_q;
    assign bus.idx_valid = valid_q;
    assign bus.locked    = (state_q == LOCK);
    assign bus.illegal   = illegal_q;
    assign bus.seq_err   = seq_err_q;
    assign bus.err_count = err_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// ----------------------------------------------------------------------------
// tb_johnson_decoder
//   Drives two decoders (ERR_W=8 and ERR_W=2) with identical stimulus and
//   compares them against a table-driven reference model of the decoding
//   and lock rules. Honours JDEC_BIDIR_EN in the model.
// ----------------------------------------------------------------------------
module tb_johnson_decoder;
    import johnson_pkg::*;

    localparam int W        = 4;
    localparam int LOCK_CNT = 3;
    localparam int NC       = 2 * W;

`ifdef JDEC_BIDIR_EN
    localparam bit BIDIR = 1'b1;
`else
    localparam bit BIDIR = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    johnson_decoder_if #(.WIDTH(W), .ERR_W(8)) bus8 ();
    johnson_decoder_if #(.WIDTH(W), .ERR_W(2)) bus2 ();

    johnson_decoder #(.WIDTH(W), .LOCK_CNT(LOCK_CNT), .ERR_W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    johnson_decoder #(.WIDTH(W), .LOCK_CNT(LOCK_CNT), .ERR_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters and check task
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [W-1:0] code_tab [NC];   // code_tab[i] = Johnson code of phase i
    int m_idx;
    bit m_valid;
    bit m_dir;
    bit m_lock;
    int m_run;
    bit m_ill;
    bit m_seq;
    int m_err8;
    int m_err2;

    task automatic build_table();
        for (int i = 0; i < NC; i++) begin
            if (i <= W) begin
                code_tab[i] = W'(((1 << i) - 1) << (W - i));
            end else begin
                code_tab[i] = W'((1 << (NC - i)) - 1);
            end
        end
    endtask

    task automatic lookup(input logic [W-1:0] code, output bit lg,
                          output int ix);
        lg = 1'b0;
        ix = 0;
        for (int i = 0; i < NC; i++) begin
            if (code_tab[i] == code) begin
                lg = 1'b1;
                ix = i;
            end
        end
    endtask

    task automatic model_reset();
        m_idx   = 0;
        m_valid = 1'b0;
        m_dir   = 1'b1;
        m_lock  = 1'b0;
        m_run   = 0;
        m_ill   = 1'b0;
        m_seq   = 1'b0;
        m_err8  = 0;
        m_err2  = 0;
    endtask

    task automatic model_step(input bit e, input logic [W-1:0] code,
                              input bit clr);
        bit lg;
        int ni;
        int d;
        bit inc;
        bit ok;
        m_ill = 1'b0;
        m_seq = 1'b0;
        inc   = 1'b0;
        if (e) begin
            lookup(code, lg, ni);
            if (!lg) begin
                m_ill  = 1'b1;
                m_run  = 0;
                m_lock = 1'b0;
                inc    = 1'b1;
            end else if (!m_valid) begin
                m_idx   = ni;
                m_valid = 1'b1;
                m_run   = 0;
            end else begin
                d  = (ni - m_idx + NC) % NC;
                ok = (d == 1) || (BIDIR && (d == NC - 1));
                if (d != 0) begin
                    m_idx = ni;
                    if (ok) begin
                        m_dir = (d == 1);
                        if (!m_lock) begin
                            m_run++;
                            if (m_run >= LOCK_CNT) m_lock = 1'b1;
                        end
                    end else begin
                        m_run = 0;
                        if (m_lock) begin
                            m_seq  = 1'b1;
                            inc    = 1'b1;
                            m_lock = 1'b0;
                        end
                    end
                end
            end
        end
        if (clr) begin
            m_err8 = 0;
            m_err2 = 0;
        end else if (inc) begin
            m_err8 = (m_err8 < 255) ? m_err8 + 1 : 255;
            m_err2 = (m_err2 < 3) ? m_err2 + 1 : 3;
        end
    endtask

    task automatic check_all();
        check_val("idx",       32'(bus8.idx),       32'(m_idx));
        check_val("idx_valid", 32'(bus8.idx_valid), 32'(m_valid));
        check_val("dir_up",    32'(bus8.dir_up),    32'(m_dir));
        check_val("locked",    32'(bus8.locked),    32'(m_lock));
        check_val("illegal",   32'(bus8.illegal),   32'(m_ill));
        check_val("seq_err",   32'(bus8.seq_err),   32'(m_seq));
        check_val("err8",      32'(bus8.err_count), 32'(m_err8));
        check_val("err2",      32'(bus2.err_count), 32'(m_err2));
        check_val("locked2",   32'(bus2.locked),    32'(m_lock));
    endtask

    // ------------------------------------------------------------------
    // Driver tasks (entered and left at a falling edge)
    // ------------------------------------------------------------------
    task automatic drive(input bit e, input logic [W-1:0] code, input bit clr);
        bus8.en = e;  bus8.jc_in = code;  bus8.clr_err = clr;
        bus2.en = e;  bus2.jc_in = code;  bus2.clr_err = clr;
        @(posedge clk);
        model_step(e, code, clr);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Directed sequence: lock + wrap, illegal, locked jump, step back,
    // then illegal codes for saturation.
    localparam int NDIR = 24;
    logic [W-1:0] dir_seq [NDIR] = '{
        4'h0, 4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0,
        4'hA,
        4'h1, 4'h0, 4'h8, 4'hC, 4'hF,
        4'h0, 4'h8, 4'hC, 4'hE, 4'hC,
        4'hA, 4'h5, 4'h9, 4'hB
    };

    // ------------------------------------------------------------------
    // Main stimulus
    // ------------------------------------------------------------------
    initial begin
        int r;
        logic [W-1:0] code;
        bit e;
        bit clr;

        build_table();
        model_reset();
        bus8.en = 1'b0;  bus8.jc_in = '0;  bus8.clr_err = 1'b0;
        bus2.en = 1'b0;  bus2.jc_in = '0;  bus2.clr_err = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Directed part; clear the counters before the saturation run
        for (int i = 0; i < NDIR; i++) begin
            if (i == 20) drive(1'b0, 4'h6, 1'b1);
            drive(1'b1, dir_seq[i], 1'b0);
        end
        // Fifth error together with clear: count ends at 0
        drive(1'b1, 4'hD, 1'b1);
        // en=0 holds everything even for garbage input
        drive(1'b0, 4'h5, 1'b0);

        // Randomized part
        for (int n = 0; n < 3000; n++) begin
            r   = $urandom_range(0, 99);
            e   = 1'b1;
            clr = ($urandom_range(0, 24) == 0);
            if (r < 40) begin
                code = m_valid ? code_tab[(m_idx + 1) % NC] : code_tab[0];
            end else if (r < 55) begin
                code = code_tab[(m_idx + NC - 1) % NC];
            end else if (r < 65) begin
                code = code_tab[m_idx];
            end else if (r < 75) begin
                code = code_tab[$urandom_range(0, NC - 1)];
            end else if (r < 88) begin
                code = W'($urandom);
            end else begin
                e    = 1'b0;
                code = W'($urandom);
            end
            drive(e, code, clr);
            if (n == 1500) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
